// File: rtl/ysyx_22050612_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, W variants.
// Optional build macro YSYX_22050612_MDU_FAST_MUL_EN: single-cycle multiply array, divide unchanged.
module ysyx_22050612_mdu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               word_q, word_d;
    logic               neg1_q, neg1_d, neg2_q, neg2_d;
    logic               fast_q, fast_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;     // product accumulator, or remainder in the low half
    logic [2*XLEN-1:0]  mcand_q, mcand_d; // shifting multiplicand, or divisor in the low half
    logic [XLEN-1:0]    mplier_q, mplier_d; // multiplier, or dividend/quotient shift register
    logic [XLEN-1:0]    res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               valid_q, valid_d;
    logic               in_ready_q, busy_q;

    logic               accept_s, word_s, s1_signed_s, s2_signed_s, sign1_s, sign2_s;
    logic               div_zero_s, div_ovf_s, last_s;
    logic [XLEN-1:0]    src1x_s, src2x_s, mag1_s, mag2_s, dvd_word_s;
    logic [XLEN:0]      rem_try_s, rem_diff_s;
    logic [2*XLEN-1:0]  acc_step_s, mcand_step_s, prod_f_s;
    logic [XLEN-1:0]    mplier_step_s, quo_f_s, rem_f_s, raw_s, final_s;

    assign accept_s = in_valid && in_ready_q && !flush;

    // Request decode: operand extension, magnitudes and the special divide cases.
    always_comb begin
        word_s      = (XLEN == 64) && in_word;
        s1_signed_s = (!word_s && (in_op == OP_MULH || in_op == OP_MULHSU)) ||
                      in_op == OP_DIV || in_op == OP_REM;
        s2_signed_s = (!word_s && in_op == OP_MULH) || in_op == OP_DIV || in_op == OP_REM;
        src1x_s     = word_s ? (s1_signed_s ? sext32(in_src1) : zext32(in_src1)) : in_src1;
        src2x_s     = word_s ? (s2_signed_s ? sext32(in_src2) : zext32(in_src2)) : in_src2;
        sign1_s     = s1_signed_s && src1x_s[XLEN-1];
        sign2_s     = s2_signed_s && src2x_s[XLEN-1];
        mag1_s      = sign1_s ? -src1x_s : src1x_s;
        mag2_s      = sign2_s ? -src2x_s : src2x_s;
        dvd_word_s  = word_s ? sext32(in_src1) : in_src1;
        div_zero_s  = in_op[2] && !(|src2x_s);
        if (word_s) begin
            div_ovf_s = in_op[2] && !in_op[0] && (in_src1[31:0] == 32'h8000_0000) &&
                        (&in_src2[31:0]);
        end else begin
            div_ovf_s = in_op[2] && !in_op[0] && (in_src1 == MIN_NEG) && (&in_src2);
        end
    end

    // One radix-2 step: restoring divide, or shift-add multiply.
    always_comb begin
        rem_try_s  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        rem_diff_s = rem_try_s - {1'b0, mcand_q[XLEN-1:0]};
        if (op_q[2]) begin
            acc_step_s    = {acc_q[2*XLEN-1:XLEN],
                             (rem_diff_s[XLEN] ? rem_try_s[XLEN-1:0] : rem_diff_s[XLEN-1:0])};
            mcand_step_s  = mcand_q;
            mplier_step_s = {mplier_q[XLEN-2:0], ~rem_diff_s[XLEN]};
        end else begin
`ifdef YSYX_22050612_MDU_FAST_MUL_EN
            acc_step_s    = {{XLEN{1'b0}}, mcand_q[XLEN-1:0]} * {{XLEN{1'b0}}, mplier_q};
            mcand_step_s  = mcand_q;
            mplier_step_s = mplier_q;
`else
            acc_step_s    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_step_s  = mcand_q << 1'b1;
            mplier_step_s = mplier_q >> 1'b1;
`endif
        end
    end

    // Sign fix-up and result selection from the post-step values.
    always_comb begin
        prod_f_s = (neg1_q ^ neg2_q) ? -acc_step_s : acc_step_s;
        quo_f_s  = (neg1_q ^ neg2_q) ? -mplier_step_s : mplier_step_s;
        rem_f_s  = neg1_q ? -acc_step_s[XLEN-1:0] : acc_step_s[XLEN-1:0];
        if (op_q[2]) begin
            raw_s = op_q[1] ? rem_f_s : quo_f_s;
        end else if (op_q == OP_MUL || word_q) begin
            raw_s = prod_f_s[XLEN-1:0];
        end else begin
            raw_s = prod_f_s[2*XLEN-1:XLEN];
        end
        final_s = word_q ? sext32(raw_s) : raw_s;
    end

`ifdef YSYX_22050612_MDU_FAST_MUL_EN
    assign last_s = !op_q[2] ||
                    (cnt_q == (word_q ? CNT_W'(5'd31) : CNT_W'(XLEN - 1)));
`else
    assign last_s = (cnt_q == (word_q ? CNT_W'(5'd31) : CNT_W'(XLEN - 1)));
`endif

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_CALC;
                else          state_d = ST_IDLE;
            end
            ST_CALC: begin
                if (fast_q || last_s) state_d = ST_DONE;
                else                  state_d = ST_CALC;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
        else       state_d = state_d;
    end

    // Datapath next-state: latch on accept, step in CALC, publish on the last step.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        fast_d   = fast_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_d    = res_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            cnt_d   = {CNT_W{1'b0}};
            op_d    = in_op;
            word_d  = word_s;
            neg1_d  = sign1_s;
            neg2_d  = sign2_s && !in_op[2] || (sign2_s && in_op[2] && !in_op[1]);
            tag_d   = in_tag;
            fast_d  = div_zero_s || div_ovf_s;
            acc_d   = {(2*XLEN){1'b0}};
            mcand_d = {{XLEN{1'b0}}, in_op[2] ? mag2_s : mag1_s};
            if (in_op[2]) mplier_d = word_s ? (mag1_s << 6'd32) : mag1_s;
            else          mplier_d = mag2_s;
            if (div_zero_s)     res_d = in_op[1] ? dvd_word_s : {XLEN{1'b1}};
            else if (div_ovf_s) res_d = in_op[1] ? {XLEN{1'b0}} : dvd_word_s;
            else                res_d = res_q;
        end else if (state_q == ST_CALC) begin
            cnt_d    = cnt_q + CNT_W'(1'b1);
            acc_d    = acc_step_s;
            mcand_d  = mcand_step_s;
            mplier_d = mplier_step_s;
            if (fast_q) begin
                valid_d = 1'b1;
            end else if (last_s) begin
                res_d   = final_s;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (state_q == ST_DONE && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= 3'd0;
            word_q     <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            fast_q     <= 1'b0;
            acc_q      <= {(2*XLEN){1'b0}};
            mcand_q    <= {(2*XLEN){1'b0}};
            mplier_q   <= {XLEN{1'b0}};
            res_q      <= {XLEN{1'b0}};
            tag_q      <= {TAG_W{1'b0}};
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            word_q     <= word_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            fast_q     <= fast_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            res_q      <= res_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            in_ready_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = valid_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// Directed self-checking bench for ysyx_22050612_mdu (XLEN=64, iterative multiply build).
module tb_ysyx_22050612_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = 64'd0;
    logic [63:0] in_src2 = 64'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22050612_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] op, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_word = word; in_src1 = a; in_src2 = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0; in_src1 = 64'd0; in_src2 = 64'd0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp_res, input int exp_lat);
        int cyc;
        present(op, word, a, b, tag);
        wait_valid(cyc);
        check_eq({name, "_lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({name, "_res"}, out_result, exp_res);
        check_eq({name, "_tag"}, 64'(out_tag), 64'(tag));
        release_result(name);
    endtask

    initial begin
        int cyc;
        int hits;

        #22;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_result", out_result, 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("div_m20_3",  3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA, 64);
        run_op("rem_m20_3",  3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run_op("rem_div0",   3'd6, 1'b0, 64'h1234, 64'd0, 5'd3, 64'h1234, 1);
        run_op("divu_div0",  3'd5, 1'b0, 64'h1234, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("mulhsu_m1",  3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run_op("mulhu_max",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run_op("divw_ovf",   3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("mulw_sext",  3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run_op("mul_m3_5",   3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd10, 64'hFFFF_FFFF_FFFF_FFF1, 64);
        run_op("mulh_m3_5",  3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run_op("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 5'd12, 64'd14, 64);
        run_op("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 5'd13, 64'd2, 64);
        run_op("divuw_sext", 3'd5, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 32);
        run_op("divw_m7_2",  3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 32);
        run_op("remw_m7_2",  3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 32);
        run_op("div_ovf64",  3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf64",  3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'd0, 1);

        // Backpressure: result and tag must hold while out_ready stays low.
        present(3'd0, 1'b0, 64'd7, 64'd6, 5'd9);
        wait_valid(cyc);
        check_eq("bp_lat", 64'(cyc), 64'd64);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
            check_eq($sformatf("bp_res_%0d", i), out_result, 64'd42);
            check_eq($sformatf("bp_tag_%0d", i), 64'(out_tag), 64'd9);
            check_eq($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        release_result("bp");

        // Flush at E0+10 of a DIVU.
        present(3'd5, 1'b0, 64'd1000, 64'd3, 5'd20);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        check_eq("fl_busy_before", 64'(busy), 64'd1);
        check_eq("fl_in_ready_before", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("fl_out_valid", 64'(out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(in_ready), 64'd1);
        check_eq("fl_busy", 64'(busy), 64'd0);
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check_eq("fl_no_result", 64'(hits), 64'd0);
        run_op("fl_mul_3_5", 3'd0, 1'b0, 64'd3, 64'd5, 5'd21, 64'd15, 64);

        // A request presented together with flush is dropped.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 64'd2; in_src2 = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flreq_busy", 64'(busy), 64'd0);
        check_eq("flreq_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a divide.
        present(3'd4, 1'b0, 64'd99, 64'd4, 5'd22);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_out_tag", 64'(out_tag), 64'd0);
        check_eq("arst_out_result", out_result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check_eq("arst_no_result", 64'(hits), 64'd0);
        run_op("arst_divu", 3'd5, 1'b0, 64'd99, 64'd4, 5'd23, 64'd24, 64);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_mdu.md
Name: ysyx_22050612_mdu

Overview:
Iterative RV64M multiply/divide unit with valid/ready handshakes on both sides. It replaces the single-cycle combinational `*`, `/` and `%` paths in the execute stage. Datapath width is parametrised; it covers the full M set plus the W (32-bit) variants. It sits beside the ALU; the execute stage holds the instruction until `out_valid`.

Parameters:
XLEN, 64, datapath width; legal values are 32 and 64.
TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous assert, active-low.
flush  in  1  synchronous kill of any in-flight or pending result.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request; high only in IDLE.
in_op  in  3  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
in_word  in  1  W variant; ignored when XLEN=32.
in_src1  in  XLEN  rs1 value.
in_src2  in  XLEN  rs2 value.
in_tag  in  TAG_W  tag, returned unchanged on `out_tag`.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_result  out  XLEN  result.
out_tag  out  TAG_W  tag of the result.
busy  out  1  high when the state is not IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_tag`=0, `busy`=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on `in_valid`&`in_ready` (the accept edge, E0). The unit latches op, word, tag and the operands.
  - Operands are latched as magnitudes for the signed forms; the sign-fix flags are latched alongside.
- CALC: one radix-2 step per edge.
  - Multiply: shift-add.
  - Divide: restoring.
  - N = 32 when `in_word` is set and XLEN=64; otherwise N = XLEN.
  - After N steps (edge E0+N) -> DONE with `out_valid`=1.
- Fast path: divide-by-zero and signed overflow go directly IDLE -> DONE at E0+1.
  - Divide-by-zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (most-negative / -1): DIV = dividend; REM = 0.
- DONE: hold `out_result` and `out_tag` stable while `out_valid`&!`out_ready`. On `out_ready` -> IDLE. No new request is accepted in the same cycle.
- Multiply result selection:
  - MUL: low XLEN bits of the product.
  - MULH / MULHSU / MULHU: high XLEN bits.
  - Signed operands use magnitudes; the 2·XLEN product is negated when the sign flags differ.
  - MULHSU treats src2 as unsigned.
- Divide sign rules:
  - Quotient is negated when the dividend and divisor signs differ (non-zero divisor).
  - Remainder takes the sign of the dividend.
- W variants (XLEN=64):
  - Operate on src[31:0]; signed forms take sign from bit 31.
  - Result bits [31:0] are sign-extended from bit 31 to 64 bits, including DIVUW and REMUW.
  - `in_word` with op 1–3 is executed as MULW.
- Flush: highest priority.
  - Any state -> IDLE on the next edge; `out_valid` is forced to 0 the cycle after.
  - A request presented in the same cycle as `flush` is not accepted.
- Asynchronous reset mid-CALC: immediately returns to the reset values; no result is produced.
- Counter wraps are impossible. The counter is cleared on every accept and is compared against N-1.

Optional Feature:
`YSYX_22050612_MDU_FAST_MUL_EN`:
- Defined: multiply ops are computed with a single-cycle `*` array and go IDLE -> DONE at E0+1. Divide is unchanged.
- Undefined: multiply is iterative with N-cycle latency as above.
- Results are bit-identical in both builds.

Test Plan:
- DIV 64-bit: src1=-20, src2=3 -> `out_result`=0xFFFFFFFFFFFFFFFA (-6). `out_valid` first high after E0+64.
- REM with src2=0: src1=0x1234 -> `out_result`=0x1234 at E0+1. DIVU with src2=0 -> 0xFFFFFFFFFFFFFFFF.
- MULHSU: src1=-1, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFFFFFFFFFE.
- DIVW: src1=0x0000000080000000, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000 at E0+1. MULW: 0x7FFFFFFF × 2 -> 0xFFFFFFFFFFFFFFFE at E0+32.
- Backpressure: hold `out_ready`=0 for 5 cycles after MUL 7×6 -> `out_result`=42 and `out_tag`=in_tag stay stable. `in_ready`=0 throughout.
- Flush at E0+10 of a DIVU -> IDLE next edge, no `out_valid`, `in_ready`=1. A following MUL 3×5 returns 15.
